// File: rtl/bt_command_rx.sv
// UART receiver (8N1, LSB first) with a one-byte ASCII command decoder.
// Direction and state requests are held levels. Byte, command and framing events are one-cycle pulses.
module bt_command_rx #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [1:0] dir,
  output logic [2:0] state_choice,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       cmd_valid,
  output logic       frame_err
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       idx, idx_d;
  logic [7:0]       sh, sh_d;
  logic             rx_m, rx_s;

  logic [1:0]       dir_d;
  logic [2:0]       state_choice_d;
  logic [7:0]       rx_data_d;
  logic             rx_valid_d, cmd_valid_d, frame_err_d;

  // Two-flop synchronizer, preset to the idle line level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      sh           <= '0;
      dir          <= 2'b00;
      state_choice <= 3'b000;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      cmd_valid    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      idx          <= idx_d;
      sh           <= sh_d;
      dir          <= dir_d;
      state_choice <= state_choice_d;
      rx_data      <= rx_data_d;
      rx_valid     <= rx_valid_d;
      cmd_valid    <= cmd_valid_d;
      frame_err    <= frame_err_d;
    end
  end

  // Next-state, bit sampling and command decode
  always_comb begin
    state_d        = state;
    cnt_d          = cnt + CNT_W'(1);
    idx_d          = idx;
    sh_d           = sh;
    dir_d          = dir;
    state_choice_d = state_choice;
    rx_data_d      = rx_data;
    rx_valid_d     = 1'b0;
    cmd_valid_d    = 1'b0;
    frame_err_d    = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == DIV_LAST) begin
          cnt_d     = '0;
          sh_d[idx] = rx_s;
          idx_d     = idx + 3'd1;
          if (idx == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == DIV_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            rx_data_d  = sh;
            rx_valid_d = 1'b1;
            state_d    = S_IDLE;
            // Letters accepted in either case; digits select game state
            case (sh)
              8'h61, 8'h41: begin dir_d = 2'b00; cmd_valid_d = 1'b1; end
              8'h64, 8'h44: begin dir_d = 2'b01; cmd_valid_d = 1'b1; end
              8'h77, 8'h57: begin dir_d = 2'b10; cmd_valid_d = 1'b1; end
              8'h73, 8'h53: begin dir_d = 2'b11; cmd_valid_d = 1'b1; end
              8'h31:        begin state_choice_d = 3'b010; cmd_valid_d = 1'b1; end
              8'h30:        begin state_choice_d = 3'b101; cmd_valid_d = 1'b1; end
              8'h72, 8'h52: begin state_choice_d = 3'b000; cmd_valid_d = 1'b1; end
              default:      ;
            endcase
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bt_command_rx.sv
// Directed bench for bt_command_rx: a frame-level model predicts every pulse and held output,
// and a per-cycle compare process checks the DUT against it.
module tb_bt_command_rx;

  localparam int BIT = 16;
  // rx fall -> 2 sync clocks -> stop sample 152 clocks later -> registered one edge after
  localparam int LAT_NOM = 2 + 152 + 1;
  localparam int LAT_TOL = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [1:0] dir;
  logic [2:0] state_choice;
  logic [7:0] rx_data;
  logic       rx_valid, cmd_valid, frame_err;

  bt_command_rx #(.CLK_HZ(1_600_000), .BAUD(100_000)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .dir(dir), .state_choice(state_choice), .rx_data(rx_data),
    .rx_valid(rx_valid), .cmd_valid(cmd_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         start;
  } ev_t;

  ev_t        q[$];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_bad = 0;
  int         n_valid = 0;
  int         n_cmd = 0;
  int         n_err = 0;
  logic [1:0] dir_m = 2'b00;
  logic [2:0] sc_m = 3'b000;
  logic [7:0] rxd_m = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // Command table: returns {is_cmd, is_dir, value[2:0]}
  function automatic logic [4:0] cmd_of(input logic [7:0] b);
    case (b)
      "a", "A": return {2'b11, 3'd0};
      "d", "D": return {2'b11, 3'd1};
      "w", "W": return {2'b11, 3'd2};
      "s", "S": return {2'b11, 3'd3};
      "1":      return {2'b10, 3'b010};
      "0":      return {2'b10, 3'b101};
      "r", "R": return {2'b10, 3'b000};
      default:  return 5'b0;
    endcase
  endfunction

  // Per-cycle compare against the model
  always @(negedge clk) begin
    ev_t        e;
    logic [4:0] c;
    int         lat;
    if (!rst) begin
      q.delete();
      dir_m = 2'b00; sc_m = 3'b000; rxd_m = 8'h00;
      chk("pulses_in_reset", {29'd0, rx_valid, cmd_valid, frame_err}, 32'd0);
    end else begin
      if (rx_valid || frame_err) begin
        chk("valid_and_err_together", 32'(rx_valid & frame_err), 32'd0);
        if (rx_valid) n_valid++;
        if (frame_err) n_err++;
        if (cmd_valid) n_cmd++;
        if (q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, rx_valid, frame_err}, 32'd0);
        end else begin
          e   = q.pop_front();
          lat = cyc - e.start;
          chk("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
          chk("pulse_latency_in_window",
              32'((lat >= LAT_NOM - LAT_TOL) && (lat <= LAT_NOM + LAT_TOL)), 32'd1);
          if (!e.is_err) begin
            c = cmd_of(e.data);
            chk("rx_data_on_valid", 32'(rx_data), 32'(e.data));
            chk("cmd_valid", 32'(cmd_valid), 32'(c[4]));
            rxd_m = e.data;
            if (c[4] && c[3]) dir_m = c[1:0];
            if (c[4] && !c[3]) sc_m = c[2:0];
          end else begin
            chk("cmd_valid_on_err", 32'(cmd_valid), 32'd0);
          end
        end
      end else begin
        chk("cmd_valid_idle", 32'(cmd_valid), 32'd0);
        if (q.size() != 0 && cyc > q[0].start + LAT_NOM + LAT_TOL) begin
          chk("missing_pulse", 32'd0, 32'd1);
          void'(q.pop_front());
        end
      end
      chk("dir_held", 32'(dir), 32'(dir_m));
      chk("state_choice_held", 32'(state_choice), 32'(sc_m));
      chk("rx_data_held", 32'(rx_data), 32'(rxd_m));
    end
  end

  task automatic send(input logic [7:0] b, input logic stop_b, input bit release_line);
    ev_t e;
    @(posedge clk); #1;
    rx       = 1'b0;
    e.is_err = !stop_b;
    e.data   = b;
    e.start  = cyc;
    q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(posedge clk); #1;
      rx = b[i];
    end
    repeat (BIT) @(posedge clk); #1;
    rx = stop_b;
    repeat (BIT) @(posedge clk); #1;
    if (release_line) rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ab;
    int         v0, c0, e0;

    idle(5);
    rst = 1'b1;
    idle(500);
    @(negedge clk);
    chk("lit_reset_dir", 32'(dir), 32'h0);
    chk("lit_reset_sc", 32'(state_choice), 32'h0);
    chk("lit_reset_rxd", 32'(rx_data), 32'h00);
    chk("lit_idle_no_pulses", 32'(n_valid + n_err + n_cmd), 32'd0);

    send(8'h77, 1'b1, 1'b1);
    @(negedge clk);
    chk("lit_w_dir", 32'(dir), 32'h2);
    chk("lit_w_sc", 32'(state_choice), 32'h0);
    send(8'h31, 1'b1, 1'b1);
    @(negedge clk);
    chk("lit_1_sc", 32'(state_choice), 32'h2);
    chk("lit_1_dir", 32'(dir), 32'h2);
    chk("lit_two_valid", 32'(n_valid), 32'd2);
    chk("lit_two_cmd", 32'(n_cmd), 32'd2);

    send(8'h5A, 1'b1, 1'b1);
    @(negedge clk);
    chk("lit_Z_rxd", 32'(rx_data), 32'h5A);
    chk("lit_Z_no_cmd", 32'(n_cmd), 32'd2);
    chk("lit_Z_dir", 32'(dir), 32'h2);
    chk("lit_Z_sc", 32'(state_choice), 32'h2);

    v0 = n_valid;
    send(8'h44, 1'b0, 1'b0);
    idle(100);
    rx = 1'b1;
    idle(20);
    @(negedge clk);
    chk("lit_break_one_err", 32'(n_err), 32'd1);
    chk("lit_break_no_valid", 32'(n_valid), 32'(v0));
    chk("lit_break_rxd", 32'(rx_data), 32'h5A);
    send(8'h30, 1'b1, 1'b1);
    @(negedge clk);
    chk("lit_0_sc", 32'(state_choice), 32'h5);

    v0 = n_valid; e0 = n_err; c0 = n_cmd;
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(60);
    @(negedge clk);
    chk("lit_glitch_quiet", 32'(n_valid + n_err + n_cmd), 32'(v0 + e0 + c0));
    send(8'h64, 1'b1, 1'b1);
    @(negedge clk);
    chk("lit_d_dir", 32'(dir), 32'h1);

    // Abort 0x73 mid bit 4 with reset; no expectation is queued for it
    ab = 8'h73;
    @(posedge clk); #1;
    rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (BIT) @(posedge clk); #1;
      rx = ab[i];
    end
    idle(8);
    v0 = n_valid;
    rst = 1'b0;
    rx  = 1'b1;
    idle(5);
    @(negedge clk);
    chk("lit_rst_dir", 32'(dir), 32'h0);
    chk("lit_rst_sc", 32'(state_choice), 32'h0);
    chk("lit_rst_rxd", 32'(rx_data), 32'h00);
    #1;
    rst = 1'b1;
    idle(200);
    @(negedge clk);
    chk("lit_abort_no_valid", 32'(n_valid), 32'(v0));
    send(8'h61, 1'b1, 1'b1);
    @(negedge clk);
    chk("lit_a_dir", 32'(dir), 32'h0);
    chk("lit_a_valid", 32'(n_valid), 32'(v0 + 1));
    chk("lit_a_rxd", 32'(rx_data), 32'h61);

    idle(200);
    chk("all_expected_pulses_seen", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bt_command_rx.md
Name: bt_command_rx

Overview:
- UART receiver and command decoder for the Bluetooth module's serial output.
- Sits directly upstream of the game state controller and the play screen.
- Converts received ASCII bytes into a held direction code `dir` and a held menu/state request `state_choice`.
- Also exposes the raw byte, a byte strobe and error flags for debug LEDs.

Parameters:
- CLK_HZ, 100_000_000: system clock frequency in Hz.
- BAUD, 9600: serial bit rate.
- DIV, CLK_HZ/BAUD (10416 at defaults): clocks per bit, derived. Must be ≥ 4.
- HALF, DIV/2: clocks from the start-bit falling edge to the start-bit mid-point, derived.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- rx  in  1  serial line from the BT module. Idle high, asynchronous to clk.
- dir  out  2  last direction command: 00 left, 01 right, 10 up, 11 down.
- state_choice  out  3  last state request: 000 none, 010 start, 101 quit.
- rx_data  out  8  last correctly framed byte.
- rx_valid  out  1  one-cycle pulse for each correctly framed byte.
- cmd_valid  out  1  one-cycle pulse, coincident with rx_valid, when the byte is a recognised command.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled as 0.

Behaviour:
- Reset (rst=0, async): `dir`=00, `state_choice`=000, `rx_data`=8'h00, all pulse outputs 0.
  - Both synchronizer flops preset to 1; FSM in IDLE; counters 0.
- Input conditioning: `rx` passes through a 2-flop synchronizer (rx_s). All decisions use rx_s, so there are 2 cycles of input latency.
- Bit counter: 16-bit. Bit index: 3-bit.
- FSM states:
  - IDLE: wait for rx_s=0 → START, counter cleared.
  - START: count to HALF-1, then sample rx_s.
    - rx_s=1: glitch, return to IDLE with no output.
    - rx_s=0: go to DATA, counter cleared, bit index 0.
  - DATA: every DIV clocks sample rx_s into shift register bit [index], LSB first. After index 7 → STOP.
  - STOP: after DIV clocks sample rx_s.
    - rx_s=1: load `rx_data`, pulse `rx_valid`, run decode, → IDLE.
    - rx_s=0: pulse `frame_err`, no decode, `rx_data` unchanged, → BREAK.
  - BREAK: wait for rx_s=1, then → IDLE. A held-low line therefore produces exactly one `frame_err`, not repeated frames.
- Timing: the stop-bit sample occurs 9.5·DIV clocks after the synchronized falling edge (±1 clk). `rx_valid`, `cmd_valid`, `rx_data`, `dir` and `state_choice` all change on the clock edge after that sample (registered, same cycle).
- Back-to-back frames: a new start bit is accepted in the cycle after returning to IDLE. No idle gap is required beyond the stop-bit half.
- Decode (case-insensitive for letters):
  - 'a'/'A' → `dir`=00; 'd'/'D' → 01; 'w'/'W' → 10; 's'/'S' → 11.
  - '1' (0x31) → `state_choice`=010; '0' (0x30) → 101; 'r'/'R' → 000.
  - A direction command leaves `state_choice` unchanged, and vice versa.
  - Any other byte: `rx_valid`=1, `cmd_valid`=0, `dir` and `state_choice` held.
- Hold rule: `dir` and `state_choice` are levels and hold until overwritten by a later command or reset. The downstream controller depends on `state_choice` staying at 010 until life conditions allow the start transition.
- Reset mid-frame: immediate return to IDLE and all outputs to reset values. The partial frame is discarded. The next falling edge after reset release starts a fresh frame.
- Glitch rejection: a low pulse shorter than HALF clocks on rx_s produces no output.
- No output pulse lasts longer than 1 cycle. `rx_valid` and `frame_err` are never asserted in the same cycle.

Test Plan:
- Sim parameters: CLK_HZ=1_600_000, BAUD=100_000 (DIV=16).
- Reset then idle line 500 clks → `dir`=00, `state_choice`=000, `rx_data`=00, no pulses.
- Send 0x77 ('w') then 0x31 ('1') back-to-back, 1 stop bit each:
  - first frame: `rx_valid` and `cmd_valid` pulse 1 cycle, `dir`=10;
  - second frame: `state_choice`=010, `dir` still 10;
  - pulse timing 152±2 clks after each start edge.
- Send 0x5A ('Z') → `rx_valid`=1, `cmd_valid`=0, `rx_data`=0x5A, `dir` and `state_choice` unchanged.
- Send 0x44 with stop bit forced 0, then hold `rx` low 100 clks, release, then send 0x30 → exactly one `frame_err` pulse, `rx_data` unchanged, no `rx_valid` for the bad frame. Following 0x30 gives `state_choice`=101.
- 5-clk low glitch on `rx`, then idle → no pulses, FSM back in IDLE. A following 0x64 ('d') gives `dir`=01.
- Assert `rst` during bit 4 of 0x73, release, send 0x61 → `dir`=00 after reset. No output from the aborted frame. Next frame decodes to `dir`=00 with `rx_valid` pulse.
